// File: rtl/nrisc_int_ctrl.sv
// Interrupt controller ahead of the NRISC PC/stack controller: edge-detects eight IRQ lines,
// latches and masks them, and issues a one-cycle prioritised vector pulse with no nesting.
module nrisc_int_ctrl #(
  parameter logic [7:0]  VECTOR_BASE   = 8'h10,
  parameter int unsigned VECTOR_STRIDE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] IRQ,
  input  logic [1:0] CORE_PC_ctrl,
  input  logic [1:0] CORE_STACK_ctrl,
  input  logic       INT_ret,
  input  logic       CFG_we,
  input  logic [1:0] CFG_sel,
  input  logic [7:0] CFG_wdata,
  output logic [7:0] CFG_rdata,
  output logic       INTERRUPT_flag,
  output logic [7:0] INTERRUPT_ch
);

  localparam logic [7:0] StrideB = 8'(VECTOR_STRIDE);

  typedef enum logic [1:0] {StIdle, StFire, StService} state_e;

  state_e     state_q, state_d;
  logic [7:0] irq_prev_q;
  logic [7:0] pending_q, pending_d;
  logic [7:0] mask_q, mask_d;
  logic       gie_q, gie_d;
  logic       flag_q, flag_d;
  logic [7:0] ch_q, ch_d;

  logic [7:0] rise, eligible, clr, fire_onehot, vector;
  logic [2:0] fire_idx;
  logic       any_eligible, quiet, fire;

  assign rise     = IRQ & ~irq_prev_q;
  assign eligible = pending_q & mask_q;
  assign quiet    = (CORE_PC_ctrl == 2'b00) && (CORE_STACK_ctrl == 2'b00);

  // Descending scan so the lowest eligible index is the one left standing.
  always_comb begin
    fire_idx     = 3'd0;
    any_eligible = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (eligible[i]) begin
        fire_idx     = 3'(i);
        any_eligible = 1'b1;
      end
    end
  end

  assign fire_onehot = 8'b1 << fire_idx;
  assign vector      = VECTOR_BASE + ({5'b0, fire_idx} * StrideB);

  always_comb begin
    state_d = state_q;
    fire    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (gie_q && any_eligible && quiet) begin
          fire    = 1'b1;
          state_d = StFire;
        end
      end
      StFire:    state_d = StService;
      StService: if (INT_ret) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    clr = fire ? fire_onehot : 8'h00;
    if (CFG_we && (CFG_sel == 2'd1)) clr = clr | CFG_wdata;
    // A rising edge in the same cycle as a clear keeps the bit set.
    pending_d = (pending_q & ~clr) | rise;
    mask_d    = (CFG_we && (CFG_sel == 2'd0)) ? CFG_wdata : mask_q;
    gie_d     = (CFG_we && (CFG_sel == 2'd2)) ? CFG_wdata[0] : gie_q;
    flag_d    = fire;
    ch_d      = fire ? vector : ch_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      irq_prev_q <= 8'h00;
      pending_q  <= 8'h00;
      mask_q     <= 8'h00;
      gie_q      <= 1'b0;
      flag_q     <= 1'b0;
      ch_q       <= 8'h00;
    end else begin
      state_q    <= state_d;
      irq_prev_q <= IRQ;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      gie_q      <= gie_d;
      flag_q     <= flag_d;
      ch_q       <= ch_d;
    end
  end

  always_comb begin
    case (CFG_sel)
      2'd0:    CFG_rdata = mask_q;
      2'd1:    CFG_rdata = pending_q;
      2'd2:    CFG_rdata = {5'b0, state_q == StService, state_q == StFire, gie_q};
      default: CFG_rdata = 8'h00;
    endcase
  end

  assign INTERRUPT_flag = flag_q;
  assign INTERRUPT_ch   = ch_q;

endmodule

// File: tb/tb_nrisc_int_ctrl.sv
// Bench for nrisc_int_ctrl: directed scenarios plus a randomized run against a
// transaction-level model; a second instance uses a wrapping vector layout.
module tb_nrisc_int_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] IRQ;
  logic [1:0] CORE_PC_ctrl, CORE_STACK_ctrl;
  logic       INT_ret, CFG_we;
  logic [1:0] CFG_sel;
  logic [7:0] CFG_wdata;
  logic [7:0] rdata0, rdata1, ch0, ch1;
  logic       flag0, flag1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nrisc_int_ctrl u_dut (
    .clk(clk), .rst(rst), .IRQ(IRQ), .CORE_PC_ctrl(CORE_PC_ctrl),
    .CORE_STACK_ctrl(CORE_STACK_ctrl), .INT_ret(INT_ret), .CFG_we(CFG_we),
    .CFG_sel(CFG_sel), .CFG_wdata(CFG_wdata), .CFG_rdata(rdata0),
    .INTERRUPT_flag(flag0), .INTERRUPT_ch(ch0)
  );

  nrisc_int_ctrl #(.VECTOR_BASE(8'hF8), .VECTOR_STRIDE(4)) u_wrap (
    .clk(clk), .rst(rst), .IRQ(IRQ), .CORE_PC_ctrl(CORE_PC_ctrl),
    .CORE_STACK_ctrl(CORE_STACK_ctrl), .INT_ret(INT_ret), .CFG_we(CFG_we),
    .CFG_sel(CFG_sel), .CFG_wdata(CFG_wdata), .CFG_rdata(rdata1),
    .INTERRUPT_flag(flag1), .INTERRUPT_ch(ch1)
  );

  // Reference model: "busy" means an interrupt was handed out and not yet returned.
  logic [7:0] m_prev, m_pend, m_mask, m_ch0, m_ch1;
  logic       m_gie, m_busy, m_flag;

  function automatic logic [7:0] vec_addr(input int base, input int stride, input int idx);
    int v;
    v = (base + idx * stride) % 256;
    return v[7:0];
  endfunction

  function automatic logic [7:0] model_rdata(input logic [1:0] sel);
    case (sel)
      2'd0:    return m_mask;
      2'd1:    return m_pend;
      2'd2:    return {5'b0, m_busy && !m_flag, m_flag, m_gie};
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_step();
    logic [7:0] rise, clr, elig;
    int idx;
    bit fire;
    if (!rst) begin
      m_prev = 0; m_pend = 0; m_mask = 0; m_gie = 0;
      m_busy = 0; m_flag = 0; m_ch0 = 0; m_ch1 = 0;
      return;
    end
    rise = IRQ & ~m_prev;
    elig = m_pend & m_mask;
    idx = -1;
    for (int i = 0; i < 8; i++) if (elig[i] && idx < 0) idx = i;
    fire = !m_busy && m_gie && idx >= 0 && CORE_PC_ctrl == 0 && CORE_STACK_ctrl == 0;
    clr = (CFG_we && CFG_sel == 2'd1) ? CFG_wdata : 8'h00;
    if (fire) begin
      clr[idx] = 1'b1;
      m_busy = 1;
      m_ch0 = vec_addr(8'h10, 2, idx);
      m_ch1 = vec_addr(8'hF8, 4, idx);
    end else if (m_busy && !m_flag && INT_ret) begin
      m_busy = 0;
    end
    m_flag = fire;
    m_pend = (m_pend & ~clr) | rise;
    m_prev = IRQ;
    if (CFG_we && CFG_sel == 2'd0) m_mask = CFG_wdata;
    if (CFG_we && CFG_sel == 2'd2) m_gie = CFG_wdata[0];
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic read_reg(input logic [1:0] sel, output logic [7:0] val);
    CFG_we = 0;
    CFG_sel = sel;
    #1;
    val = rdata0;
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [7:0] data);
    CFG_we = 1; CFG_sel = sel; CFG_wdata = data;
    tick();
    CFG_we = 0;
  endtask

  task automatic pulse_ret();
    INT_ret = 1;
    tick();
    INT_ret = 0;
  endtask

  task automatic test_reset();
    logic [7:0] r;
    rst = 0;
    tick(); tick();
    if (flag0 !== 1'b0 || ch0 !== 8'h00) begin
      n_err++; $display("FAIL reset_out: flag=%b ch=%h want 0/00", flag0, ch0);
    end
    n_vec++;
    for (int s = 0; s < 4; s++) begin
      read_reg(2'(s), r);
      n_vec++;
      if (r !== 8'h00) begin n_err++; $display("FAIL reset_reg%0d: got %h want 00", s, r); end
    end
    rst = 1;
    tick();
  endtask

  task automatic test_basic_fire();
    logic [7:0] r;
    cfg_write(2'd0, 8'hFF);
    cfg_write(2'd2, 8'h01);
    IRQ = 8'h08;
    tick();
    IRQ = 8'h00;
    n_vec++;
    if (flag0 !== 1'b0) begin n_err++; $display("FAIL basic_early: flag=%b want 0", flag0); end
    tick();
    n_vec++;
    if (flag0 !== 1'b1 || ch0 !== 8'h16) begin
      n_err++; $display("FAIL basic_fire: flag=%b ch=%h want 1/16", flag0, ch0);
    end
    read_reg(2'd1, r);
    n_vec++;
    if (r !== 8'h00) begin n_err++; $display("FAIL basic_pend: got %h want 00", r); end
    tick();
    n_vec++;
    if (flag0 !== 1'b0 || ch0 !== 8'h16) begin
      n_err++; $display("FAIL basic_drop: flag=%b ch=%h want 0/16", flag0, ch0);
    end
    read_reg(2'd2, r);
    n_vec++;
    if (r !== 8'h05) begin n_err++; $display("FAIL basic_state: got %h want 05", r); end
  endtask

  task automatic test_priority();
    logic [7:0] r;
    pulse_ret();
    IRQ = 8'h22;
    tick();
    IRQ = 8'h00;
    tick();
    n_vec++;
    if (flag0 !== 1'b1 || ch0 !== 8'h12) begin
      n_err++; $display("FAIL prio_first: flag=%b ch=%h want 1/12", flag0, ch0);
    end
    read_reg(2'd1, r);
    n_vec++;
    if (r !== 8'h20) begin n_err++; $display("FAIL prio_pend: got %h want 20", r); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (flag0 !== 1'b0) begin n_err++; $display("FAIL prio_nest: flag=%b want 0", flag0); end
    end
    pulse_ret();
    n_vec++;
    if (flag0 !== 1'b0) begin n_err++; $display("FAIL prio_ret: flag=%b want 0", flag0); end
    tick();
    n_vec++;
    if (flag0 !== 1'b1 || ch0 !== 8'h1A) begin
      n_err++; $display("FAIL prio_second: flag=%b ch=%h want 1/1A", flag0, ch0);
    end
    tick();
    pulse_ret();
  endtask

  task automatic test_quiet();
    CORE_PC_ctrl = 2'b01;
    IRQ = 8'h01;
    tick();
    IRQ = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (flag0 !== 1'b0) begin n_err++; $display("FAIL quiet_hold: flag=%b want 0", flag0); end
    end
    CORE_PC_ctrl = 2'b00;
    tick();
    n_vec++;
    if (flag0 !== 1'b1 || ch0 !== 8'h10) begin
      n_err++; $display("FAIL quiet_fire: flag=%b ch=%h want 1/10", flag0, ch0);
    end
    tick();
    pulse_ret();
  endtask

  task automatic test_mask_w1c();
    logic [7:0] r;
    cfg_write(2'd0, 8'hFE);
    IRQ = 8'h01;
    tick();
    IRQ = 8'h00;
    tick(); tick();
    n_vec++;
    if (flag0 !== 1'b0) begin n_err++; $display("FAIL mask_flag: flag=%b want 0", flag0); end
    read_reg(2'd1, r);
    n_vec++;
    if (r !== 8'h01) begin n_err++; $display("FAIL mask_pend: got %h want 01", r); end
    IRQ = 8'h01;
    cfg_write(2'd1, 8'h01);
    IRQ = 8'h00;
    read_reg(2'd1, r);
    n_vec++;
    if (r !== 8'h01) begin n_err++; $display("FAIL w1c_setwins: got %h want 01", r); end
    cfg_write(2'd1, 8'h01);
    read_reg(2'd1, r);
    n_vec++;
    if (r !== 8'h00) begin n_err++; $display("FAIL w1c_clear: got %h want 00", r); end
  endtask

  task automatic test_wrap();
    cfg_write(2'd0, 8'hFF);
    IRQ = 8'h04;
    tick();
    IRQ = 8'h00;
    tick();
    n_vec++;
    if (flag1 !== 1'b1 || ch1 !== 8'h00 || ch0 !== 8'h14) begin
      n_err++; $display("FAIL wrap: flag=%b ch_wrap=%h ch=%h want 1/00/14", flag1, ch1, ch0);
    end
    tick();
    pulse_ret();
  endtask

  task automatic test_reset_mid_service();
    logic [7:0] r;
    IRQ = 8'h01;
    tick();
    IRQ = 8'h80;
    tick();
    IRQ = 8'h00;
    tick();
    read_reg(2'd1, r);
    n_vec++;
    if (r !== 8'h80) begin n_err++; $display("FAIL rms_pend: got %h want 80", r); end
    read_reg(2'd2, r);
    n_vec++;
    if (r !== 8'h05) begin n_err++; $display("FAIL rms_state: got %h want 05", r); end
    rst = 0;
    tick();
    rst = 1;
    n_vec++;
    if (flag0 !== 1'b0 || ch0 !== 8'h00 || ch1 !== 8'h00) begin
      n_err++; $display("FAIL rms_out: flag=%b ch=%h/%h want 0/00/00", flag0, ch0, ch1);
    end
    for (int s = 0; s < 3; s++) begin
      read_reg(2'(s), r);
      n_vec++;
      if (r !== 8'h00) begin n_err++; $display("FAIL rms_reg%0d: got %h want 00", s, r); end
    end
    pulse_ret();
    read_reg(2'd2, r);
    n_vec++;
    if (r !== 8'h00 || flag0 !== 1'b0) begin
      n_err++; $display("FAIL rms_ret: ctrl=%h flag=%b want 00/0", r, flag0);
    end
  endtask

  task automatic test_random();
    logic [7:0] r, want;
    logic       prev_flag;
    logic [1:0] sel;
    rst = 0;
    tick();
    rst = 1;
    cfg_write(2'd0, 8'($urandom) | 8'h11);
    cfg_write(2'd2, 8'h01);
    prev_flag = 0;
    for (int i = 0; i < 600; i++) begin
      rst             = ($urandom_range(0, 149) != 0);
      IRQ             = IRQ ^ 8'($urandom & $urandom & $urandom);
      CORE_PC_ctrl    = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      CORE_STACK_ctrl = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b00;
      INT_ret         = ($urandom_range(0, 4) == 0);
      CFG_we          = ($urandom_range(0, 9) == 0);
      CFG_sel         = 2'($urandom);
      CFG_wdata       = 8'($urandom);
      if (CFG_sel == 2'd2) CFG_wdata = {7'b0, $urandom_range(0, 3) != 0};
      tick();
      n_vec++;
      if (flag0 !== m_flag || ch0 !== m_ch0 || flag1 !== m_flag || ch1 !== m_ch1) begin
        n_err++;
        $display("FAIL rand_out[%0d]: flag=%b/%b ch=%h/%h want %b %h/%h",
                 i, flag0, flag1, ch0, ch1, m_flag, m_ch0, m_ch1);
      end
      n_vec++;
      if (flag0 && prev_flag) begin
        n_err++; $display("FAIL rand_consec[%0d]: flag=1 two cycles, want single pulse", i);
      end
      prev_flag = flag0;
      sel = 2'($urandom);
      read_reg(sel, r);
      want = model_rdata(sel);
      n_vec++;
      if (r !== want) begin
        n_err++; $display("FAIL rand_rd[%0d] sel%0d: got %h want %h", i, sel, r, want);
      end
    end
    INT_ret = 0; CORE_PC_ctrl = 0; CORE_STACK_ctrl = 0; rst = 1;
  endtask

  initial begin
    rst = 0; IRQ = 0; CORE_PC_ctrl = 0; CORE_STACK_ctrl = 0; INT_ret = 0;
    CFG_we = 0; CFG_sel = 0; CFG_wdata = 0;
    test_reset();
    test_basic_fire();
    test_priority();
    test_quiet();
    test_mask_w1c();
    test_wrap();
    test_reset_mid_service();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nrisc_int_ctrl.md
# nrisc_int_ctrl

Interrupt controller sitting directly upstream of the NRISC PC/stack controller. It edge-detects eight interrupt request lines, latches them as pending, masks and prioritises them, and emits a single-cycle `INTERRUPT_flag` pulse with an 8-bit vector on `INTERRUPT_ch`. The pulse makes the PC controller load the vector and push the PC stack. The block holds off firing while the core is jumping or touching the stack, and it blocks nesting until the core signals return-from-interrupt.

## Interface
- `VECTOR_BASE`, default 8'h10: vector address of IRQ 0.
- `VECTOR_STRIDE`, default 2: vector spacing between consecutive IRQ indices.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-low (`rst`=0 resets on the next rising edge).
- `IRQ`  in  8  interrupt request lines, synchronous to `clk`; rising edge sensitive.
- `CORE_PC_ctrl`  in  2  core PC control; nonzero means a jump is in progress.
- `CORE_STACK_ctrl`  in  2  core stack control; nonzero means a push or pop is in progress.
- `INT_ret`  in  1  one-cycle pulse from the core on return-from-interrupt.
- `CFG_we`  in  1  configuration write strobe.
- `CFG_sel`  in  2  register select: 0 = mask, 1 = pending (write-1-to-clear), 2 = control (bit0 = GIE).
- `CFG_wdata`  in  8  configuration write data.
- `CFG_rdata`  out  8  combinational readback of the register chosen by `CFG_sel`.
  - sel 0: mask.
  - sel 1: pending.
  - sel 2: {5'b0, state==SERVICE, state==FIRE, GIE}.
  - sel 3: 8'h00.
- `INTERRUPT_flag`  out  1  registered one-cycle interrupt request to the PC controller.
- `INTERRUPT_ch`  out  8  registered vector address, valid while `INTERRUPT_flag`=1.

## Operation
- Reset (`rst`=0):
  - `IRQ_prev`, pending, mask, GIE cleared; state = IDLE.
  - `INTERRUPT_flag`=0, `INTERRUPT_ch`=8'h00.
- Edge detect: `rise = IRQ & ~IRQ_prev`. `IRQ_prev` is updated every cycle; a held-high line sets pending only once.
- Pending update each edge: `pending_next = (pending & ~clr) | rise`.
  - `clr` combines two sources: the CFG W1C data when `CFG_we` and sel=1, and the one-hot bit of the IRQ being fired.
  - A set always beats a simultaneous clear of the same bit.
- Eligible set = `pending & mask`. Priority: lowest index wins.
- Vector = `VECTOR_BASE + idx*VECTOR_STRIDE`, truncated to 8 bits (wraps mod 256).
- The `quiet` condition is `CORE_PC_ctrl==0 && CORE_STACK_ctrl==0`.
- FSM states:
  - IDLE: if GIE and eligible≠0 and quiet, go to FIRE. In the same edge, register `INTERRUPT_flag`=1, load `INTERRUPT_ch`=vector, and clear that pending bit.
  - FIRE (one cycle, flag visible): drop the flag to 0 and go to SERVICE. `INTERRUPT_ch` holds its value.
  - SERVICE: no new fire. On `INT_ret`=1, go to IDLE. New IRQ edges still latch as pending.
- `INT_ret` outside SERVICE is ignored.
- CFG writes take effect at the edge:
  - sel 0: loads the mask.
  - sel 2: loads GIE from bit0.
- Mask or GIE changes affect only later fire decisions; a fire already issued is never retracted.
- Clearing GIE while in SERVICE does not leave SERVICE; only `INT_ret` does.
- Reset asserted in any state returns to IDLE with all outputs at reset values on that edge, including a reset during FIRE.

## Timing
- IRQ sampled 0 at edge k-1 and 1 at edge k: the pending bit is set after edge k.
- Earliest `INTERRUPT_flag`=1 is after edge k+1: 2-cycle latency, provided IDLE, GIE, mask bit set, and quiet at edge k+1.
- `INTERRUPT_flag` is high for exactly one cycle; it is never high on two consecutive cycles.
- If not quiet, the fire is deferred cycle by cycle until the first quiet edge, with no loss of pending state.
- After `INT_ret` is sampled at edge m, state is IDLE after m. The next fire can occur at edge m+1, so the flag can be high after m+1.
- `CFG_rdata` reflects register state after the last edge; it is combinational on `CFG_sel`.

## Test plan
- Reset then basic fire:
  - Stimulus: mask=8'hFF, GIE=1, pulse IRQ[3] at edge 10, `CORE_*`=0.
  - Required: flag=1 with ch=8'h16 during the cycle after edge 11 only; pending=0; state SERVICE.
- Priority and non-nesting:
  - Stimulus: IRQ[5] and IRQ[1] rise together.
  - Required: ch=8'h12 first, pending=8'h20.
  - Then `INT_ret`: next flag carries ch=8'h1A.
- Quiet hold-off:
  - Stimulus: IRQ[0] pending while `CORE_PC_ctrl`=2'b01 for 3 cycles.
  - Required: no flag during those cycles; flag with ch=8'h10 one cycle after `CORE_PC_ctrl` returns to 0.
- Mask and W1C:
  - Stimulus: mask=8'hFE, IRQ[0] rises.
  - Required: pending=8'h01, no flag.
  - Then W1C 8'h01 in the same cycle as a new IRQ[0] edge: pending stays 8'h01 (set wins).
- Vector wrap:
  - Stimulus: `VECTOR_BASE`=8'hF8, `VECTOR_STRIDE`=4, fire IRQ[2].
  - Required: ch=8'h00.
- Reset mid-service:
  - Stimulus: `rst`=0 while in SERVICE with pending=8'h80.
  - Required: after the edge, pending=0, mask=0, GIE=0, flag=0, ch=0, state IDLE; `INT_ret` is then ignored.
